// File: rtl/riscv_pipe_pkg.sv
// Shared fetch/decode pipeline definitions: bubble instruction, reset PC, fetch FSM encoding.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus; one outstanding request at a time.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_pc_sel.sv
// Next fetch-PC priority mux: branch over jal (branch is the older instruction), then pc+4.
// Purely combinational, zero latency.
module fetch_pc_sel (
  input  logic [31:0] pc_q,
  input  logic        advance,
  input  logic        flush_branch,
  input  logic        flush_jal,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  output logic        redirect,
  output logic [31:0] pc_next
);

  assign redirect = flush_branch | flush_jal;

  always_comb begin
    pc_next = pc_q;
    if (flush_branch)
      pc_next = branch_target;
    else if (flush_jal)
      pc_next = jal_target;
    else if (advance)
      pc_next = pc_q + 32'd4;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: one outstanding imem request, 1-entry output buffer; gnt in N gives fetch_valid in N+2.
// Stalled by IFID_write=0 (no issue while buffer full); redirects drop in-flight responses.
module if_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    IFID_write,
  input  logic                    flush_jal,
  input  logic                    flush_branch,
  input  logic [31:0]             jal_target,
  input  logic [31:0]             branch_target,
  if_fetch_unit_if.master         imem,
  output logic [31:0]             pc_out,
  output logic [31:0]             instr_out,
  output logic                    fetch_valid
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic [31:0]  inflight_pc;
  logic         ob_valid;
  logic [31:0]  ob_pc;
  logic [31:0]  ob_instr;

  logic redirect;
  logic consume;
  logic issue;
  logic fire;
  logic load;

  assign consume = ob_valid & IFID_write & ~redirect;
  // Gated by reset so the bus stays quiet while reset is held.
  assign issue   = reset & (state == REQ) & ~redirect & (~ob_valid | consume);
  assign fire    = issue & imem.imem_gnt;
  assign load    = (state == WAIT) & imem.imem_rvalid & ~redirect;

  fetch_pc_sel u_pc_sel (
    .pc_q          (pc_q),
    .advance       (fire),
    .flush_branch  (flush_branch),
    .flush_jal     (flush_jal),
    .branch_target (branch_target),
    .jal_target    (jal_target),
    .redirect      (redirect),
    .pc_next       (pc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= REQ;
      pc_q        <= RESET_PC;
      inflight_pc <= 32'd0;
      ob_valid    <= 1'b0;
      ob_pc       <= 32'd0;
      ob_instr    <= NOP_INSTR;
    end else begin
      pc_q <= pc_next;
      if (fire)
        inflight_pc <= pc_q;

      case (state)
        REQ:     if (fire) state <= WAIT;
        WAIT: begin
          if (imem.imem_rvalid)
            state <= REQ;
          else if (redirect)
            state <= DROP;
        end
        DROP:    if (imem.imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase

      // Buffer is always empty when a response lands, so load never overwrites live data.
      if (redirect) begin
        ob_valid <= 1'b0;
      end else if (load) begin
        ob_valid <= 1'b1;
        ob_pc    <= inflight_pc;
        ob_instr <= imem.imem_rdata;
      end else if (consume) begin
        ob_valid <= 1'b0;
      end
    end
  end

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  assign pc_out      = ob_pc;
  assign instr_out   = ob_valid ? ob_instr : NOP_INSTR;
  assign fetch_valid = ob_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: bench drives the imem side by hand, cycle by cycle.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        IFID_write;
  logic        flush_jal;
  logic        flush_branch;
  logic [31:0] jal_target;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        fetch_valid;

  if_fetch_unit_if imem_bus ();

  int n_tests = 0;
  int n_fail  = 0;
  int stray_cnt = 0;
  logic outstanding;

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .IFID_write    (IFID_write),
    .flush_jal     (flush_jal),
    .flush_branch  (flush_branch),
    .jal_target    (jal_target),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .fetch_valid   (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: flags any rvalid that has no granted request behind it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= 1'b0;
    end else begin
      if (imem_bus.imem_rvalid) begin
        if (!outstanding) stray_cnt <= stray_cnt + 1;
        outstanding <= 1'b0;
      end
      if (imem_bus.imem_req && imem_bus.imem_gnt)
        outstanding <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset                = 1'b0;
    IFID_write           = 1'b1;
    flush_jal            = 1'b0;
    flush_branch         = 1'b0;
    jal_target           = 32'd0;
    branch_target        = 32'd0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'd0;

    #2;
    check("rst_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_pc",    pc_out, 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);

    // first fetch, 1-cycle memory
    next_cycle();
    reset = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    #1;
    check("f0_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("f0_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h00A0_0093;
    #1;
    check("f0_wait_req", {31'd0, imem_bus.imem_req}, 32'd0);

    // stall: IFID_write low for 3 cycles with buffer full
    next_cycle();
    imem_bus.imem_rvalid = 1'b0;
    IFID_write = 1'b0;
    #1;
    check("f0_valid", {31'd0, fetch_valid}, 32'd1);
    check("f0_pc",    pc_out, 32'h0);
    check("f0_instr", instr_out, 32'h00A0_0093);
    check("stall_req0", {31'd0, imem_bus.imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      check("stall_pc",    pc_out, 32'h0);
      check("stall_instr", instr_out, 32'h00A0_0093);
      check("stall_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    end
    next_cycle();
    IFID_write = 1'b1;
    imem_bus.imem_gnt = 1'b1;
    #1;
    check("resume_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("resume_addr", imem_bus.imem_addr, 32'h4);
    next_cycle();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h0020_0113;
    #1;
    check("f1_consumed", {31'd0, fetch_valid}, 32'd0);
    check("f1_wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
    next_cycle();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_gnt    = 1'b1;
    #1;
    check("f1_valid", {31'd0, fetch_valid}, 32'd1);
    check("f1_pc",    pc_out, 32'h4);
    check("f1_instr", instr_out, 32'h0020_0113);
    check("f2_addr",  imem_bus.imem_addr, 32'h8);

    // branch flush in WAIT, late response dropped
    next_cycle();
    imem_bus.imem_gnt = 1'b0;
    flush_branch  = 1'b1;
    branch_target = 32'h100;
    #1;
    check("br_flush_req", {31'd0, imem_bus.imem_req}, 32'd0);
    next_cycle();
    flush_branch = 1'b0;
    #1;
    check("drop_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check("drop_valid", {31'd0, fetch_valid}, 32'd0);
    next_cycle();
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("drop_rv_req", {31'd0, imem_bus.imem_req}, 32'd0);
    next_cycle();
    imem_bus.imem_rvalid = 1'b0;
    #1;
    check("br_valid", {31'd0, fetch_valid}, 32'd0);
    check("br_instr", instr_out, NOP);
    check("br_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    check("br_addr",  imem_bus.imem_addr, 32'h100);

    // simultaneous jal + branch: branch target wins
    next_cycle();
    flush_jal     = 1'b1;
    flush_branch  = 1'b1;
    jal_target    = 32'h200;
    branch_target = 32'h300;
    imem_bus.imem_gnt = 1'b1;
    #1;
    check("both_flush_req", {31'd0, imem_bus.imem_req}, 32'd0);
    next_cycle();
    flush_jal    = 1'b0;
    flush_branch = 1'b0;
    #1;
    check("both_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("both_addr", imem_bus.imem_addr, 32'h300);

    // jal flush coinciding with rvalid in WAIT
    next_cycle();
    imem_bus.imem_gnt    = 1'b0;
    flush_jal            = 1'b1;
    jal_target           = 32'h40;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h1234_5678;
    #1;
    check("jal_rv_req", {31'd0, imem_bus.imem_req}, 32'd0);
    next_cycle();
    flush_jal            = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_gnt    = 1'b1;
    #1;
    check("jal_instr", instr_out, NOP);
    check("jal_valid", {31'd0, fetch_valid}, 32'd0);
    check("jal_req",   {31'd0, imem_bus.imem_req}, 32'd1);
    check("jal_addr",  imem_bus.imem_addr, 32'h40);

    // reset mid-WAIT, stray rvalid after release
    next_cycle();
    imem_bus.imem_gnt = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, imem_bus.imem_req}, 32'd0);
    check("mid_rst_pc",    pc_out, 32'h0);
    check("mid_rst_instr", instr_out, NOP);
    check("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
    next_cycle();
    reset = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hBADB_AD00;
    #1;
    check("post_rst_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("post_rst_addr", imem_bus.imem_addr, 32'h0);
    next_cycle();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_gnt    = 1'b1;
    #1;
    check("stray_seen",  stray_cnt, 32'd1);
    check("stray_valid", {31'd0, fetch_valid}, 32'd0);
    check("stray_addr",  imem_bus.imem_addr, 32'h0);
    next_cycle();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h00A0_0093;
    next_cycle();
    imem_bus.imem_rvalid = 1'b0;
    #1;
    check("refetch_valid", {31'd0, fetch_valid}, 32'd1);
    check("refetch_pc",    pc_out, 32'h0);
    check("refetch_instr", instr_out, 32'h00A0_0093);
    check("refetch_addr",  imem_bus.imem_addr, 32'h4);

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Owns the fetch PC and issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake.
- Holds the returned instruction in a 1-entry output buffer until IF/ID accepts it.
- Obeys the same stall (IFID_write) and redirect (flush_jal / flush_branch) controls the IF/ID register obeys, and discards wrong-path responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when no valid fetch is available (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  asynchronous, active-low reset.
- IFID_write  in  1  IF/ID accepts the presented pair this cycle (0 = stall).
- flush_jal  in  1  redirect to jal_target.
- flush_branch  in  1  redirect to branch_target.
- jal_target  in  32  jal redirect address.
- branch_target  in  32  taken-branch redirect address.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction.
- pc_out  out  32  PC presented to IF/ID (its pc_in).
- instr_out  out  32  instruction presented to IF/ID (its instr_in).
- fetch_valid  out  1  presented pair is a real instruction.

Behaviour:
- Reset (async assert, reset==0):
  - pc_q = RESET_PC; state = REQ.
  - ob_valid = 0, ob_pc = 0, ob_instr = NOP_INSTR, inflight_pc = 0.
  - Outputs during reset: imem_req=0, pc_out=0, instr_out=NOP_INSTR, fetch_valid=0.
- Redirect:
  - redirect = flush_branch | flush_jal.
  - Target = branch_target if flush_branch is set, else jal_target. Branch wins when both are set, because it is the older instruction.
  - On redirect: pc_q <= target and ob_valid <= 0.
- Consume: consume = ob_valid & IFID_write & ~redirect.
  - On consume, ob_valid <= 0, unless a response is written into the buffer in the same cycle.
- Outputs (combinational from ob_*):
  - pc_out = ob_pc.
  - instr_out = ob_valid ? ob_instr : NOP_INSTR.
  - fetch_valid = ob_valid.
- State REQ:
  - imem_req = ~redirect & (~ob_valid | consume); imem_addr = pc_q.
  - imem_req is never asserted in a redirect cycle.
  - On imem_req & imem_gnt: inflight_pc <= pc_q; pc_q <= pc_q + 4 (wraps modulo 2^32); go to WAIT.
  - A redirect in REQ only updates pc_q; the state stays REQ.
- State WAIT (imem_req = 0):
  - rvalid & ~redirect: ob_valid <= 1, ob_pc <= inflight_pc, ob_instr <= imem_rdata; go to REQ.
  - rvalid & redirect: response discarded; go to REQ.
  - ~rvalid & redirect: go to DROP.
- State DROP (imem_req = 0):
  - On rvalid: discard the response and go to REQ.
  - A further redirect in DROP updates pc_q only (the newest target wins); the state stays DROP.
- Invariant: the output buffer is empty whenever a response arrives, because issue requires a free or consumed buffer. No overflow is possible.
- Memory contract:
  - imem_rvalid arrives at least 1 cycle after imem_gnt.
  - Exactly one rvalid per grant.
  - rvalid with no request outstanding is illegal; the bench asserts on it.
- Timing:
  - Minimum latency: gnt in cycle N, rvalid in N+1, fetch_valid in N+2.
  - Peak throughput: 1 instruction per 2 cycles.
- Stall: with IFID_write=0, ob_* is held unchanged and no new request is issued while ob_valid=1.
- The PC is not checked for alignment. Targets are used verbatim.

Decomposition:
- Shared package (riscv_pipe_pkg): NOP_INSTR constant, RESET_PC default, fetch state encoding (REQ, WAIT, DROP).
- The IF/ID register will reuse NOP_INSTR from this package.
- Optional sub-module fetch_pc_sel: combinational next-PC/target priority mux (pc+4, branch_target, jal_target).
- Everything else stays in one module.

Test Plan:
- Reset release with 1-cycle-latency memory returning 0x00A00093 at addr 0 → imem_addr=0x0; fetch_valid=1, pc_out=0x0, instr_out=0x00A00093 two cycles after gnt; next imem_addr=0x4.
- IFID_write=0 for 3 cycles while ob_valid=1 → pc_out and instr_out held; imem_req=0 throughout; fetch resumes on the first IFID_write=1 cycle.
- flush_branch with branch_target=0x100 while in WAIT and rvalid arrives 2 cycles later → response discarded (fetch_valid stays 0); next imem_addr=0x100.
- flush_jal=1 and flush_branch=1 together, jal_target=0x200, branch_target=0x300 → next imem_addr=0x300; imem_req=0 in the flush cycle.
- flush_jal in the same cycle as rvalid in WAIT, target 0x40 → instr_out=NOP_INSTR, fetch_valid=0; next request at 0x40 on the following cycle.
- reset asserted mid-WAIT, with rvalid arriving after release → outputs immediately return to reset values; post-reset fetch starts at RESET_PC; the stray rvalid is flagged by the bench.
